// File: rtl/gb_frame_writer.sv
// PPU pixel stream to framebuffer RAM write cycles, with x/y tracking and a resync on frame start.
// Define GB_FB_DOUBLE_BUFFER_EN for two pages with a page flip gated by the reader's release.
module gb_frame_writer #(
  parameter int WIDTH       = 160,
  parameter int HEIGHT      = 144,
  parameter int PIX_W       = 2,
  parameter int SYNC_STAGES = 2,
  localparam int PA_W       = $clog2(WIDTH * HEIGHT),
`ifdef GB_FB_DOUBLE_BUFFER_EN
  localparam int ADDR_W     = PA_W + 1
`else
  localparam int ADDR_W     = PA_W
`endif
) (
  input  logic              GameBoy_clk,
  input  logic              GameBoy_reset,
  input  logic [PIX_W-1:0]  LD,
  input  logic              PX_VALID,
  input  logic              FRAME_START,
`ifdef GB_FB_DOUBLE_BUFFER_EN
  input  logic              rd_done_tgl,
`endif
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              wr_page,
  output logic              disp_page,
  output logic              frame_tgl,
  output logic              short_frame,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int X_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int Y_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  if (SYNC_STAGES < 2) begin : g_sync_stages_check
    $error("SYNC_STAGES must be at least 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_COMMIT, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [X_W-1:0]  x, cur_x;
  logic [Y_W-1:0]  y, cur_y;
  logic [PA_W-1:0] idx, cur_idx;
  logic            cur_last;
  logic            accept, restart, commit, short_nxt, overflow_nxt;

  // A frame start rewinds the position before the same-cycle pixel is placed.
  assign cur_x    = restart ? '0 : x;
  assign cur_y    = restart ? '0 : y;
  assign cur_idx  = restart ? '0 : idx;
  assign cur_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) state <= S_IDLE;
    else               state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    restart      = 1'b0;
    commit       = 1'b0;
    short_nxt    = 1'b0;
    overflow_nxt = 1'b0;
    if (FRAME_START) begin
      restart   = 1'b1;
      accept    = PX_VALID;
      commit    = (state == S_COMMIT);
      short_nxt = (state == S_ACTIVE) && (idx != '0);
      state_nxt = S_ACTIVE;
    end else begin
      case (state)
        S_IDLE: ;
        S_ACTIVE: if (PX_VALID) begin
          accept = 1'b1;
          if (cur_last) state_nxt = S_COMMIT;
        end
        S_COMMIT: begin
          commit       = 1'b1;
          overflow_nxt = PX_VALID;
          state_nxt    = S_DONE;
        end
        S_DONE:  overflow_nxt = PX_VALID;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Incremental raster position; the linear index never needs a multiplier.
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end else if (accept) begin
      if (cur_x == X_LAST) begin
        x <= '0;
        y <= (cur_y == Y_LAST) ? '0 : cur_y + Y_W'(1);
      end else begin
        x <= cur_x + X_W'(1);
      end
      idx <= cur_last ? '0 : cur_idx + PA_W'(1);
    end else if (restart) begin
      x   <= '0;
      y   <= '0;
      idx <= '0;
    end
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      short_frame <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_en       <= accept;
      short_frame <= short_nxt;
      overflow    <= overflow_nxt;
      if (accept) begin
`ifdef GB_FB_DOUBLE_BUFFER_EN
        wr_addr <= {wr_page, cur_idx};
`else
        wr_addr <= cur_idx;
`endif
        wr_data <= LD;
      end
    end
  end

`ifdef GB_FB_DOUBLE_BUFFER_EN
  logic [SYNC_STAGES-1:0] rd_sync;
  logic                   rd_sync_q, rd_edge, released;

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      rd_sync   <= '0;
      rd_sync_q <= 1'b0;
    end else begin
      rd_sync   <= {rd_sync[SYNC_STAGES-2:0], rd_done_tgl};
      rd_sync_q <= rd_sync[SYNC_STAGES-1];
    end
  end

  assign rd_edge = rd_sync[SYNC_STAGES-1] ^ rd_sync_q;

  // A release edge arriving in the commit cycle survives the flip's clear.
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      wr_page   <= 1'b0;
      disp_page <= 1'b1;
      frame_tgl <= 1'b0;
      drop_cnt  <= 8'd0;
      released  <= 1'b1;
    end else begin
      released <= (released & ~commit) | rd_edge;
      if (commit) begin
        if (released) begin
          wr_page   <= disp_page;
          disp_page <= wr_page;
          frame_tgl <= ~frame_tgl;
        end else if (drop_cnt != 8'hFF) begin
          drop_cnt <= drop_cnt + 8'd1;
        end
      end
    end
  end
`else
  assign wr_page   = 1'b0;
  assign disp_page = 1'b0;
  assign drop_cnt  = 8'd0;

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) frame_tgl <= 1'b0;
    else if (commit)   frame_tgl <= ~frame_tgl;
  end
`endif

endmodule

// File: tb/tb_gb_frame_writer.sv
// Randomised bench for gb_frame_writer against a pixel-count reference model of the frame rules.
// Follows the GB_FB_DOUBLE_BUFFER_EN setting of the build.
`timescale 1ns/1ps
module tb_gb_frame_writer;

  localparam int WIDTH       = 160;
  localparam int HEIGHT      = 144;
  localparam int PIX         = WIDTH * HEIGHT;
  localparam int SYNC_STAGES = 2;
  localparam int PAGE_OFS    = 32768;
`ifdef GB_FB_DOUBLE_BUFFER_EN
  localparam int AW = 16;
`else
  localparam int AW = 15;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    ld_in = '0;
  logic          px_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic          rd_done_tgl = 1'b0;
  logic          wr_en, wr_page, disp_page, frame_tgl, short_frame, overflow;
  logic [AW-1:0] wr_addr;
  logic [1:0]    wr_data;
  logic [7:0]    drop_cnt;

  gb_frame_writer dut (
    .GameBoy_clk   (clk),
    .GameBoy_reset (rst),
    .LD            (ld_in),
    .PX_VALID      (px_valid),
    .FRAME_START   (frame_start),
`ifdef GB_FB_DOUBLE_BUFFER_EN
    .rd_done_tgl   (rd_done_tgl),
`endif
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_page       (wr_page),
    .disp_page     (disp_page),
    .frame_tgl     (frame_tgl),
    .short_frame   (short_frame),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int s = 0;

  // Reference model: frame phase, pixels taken this frame, pages, release flag.
  int   m_phase;       // 0 waiting for first frame, 1 collecting, 2 frame complete
  int   m_n;
  bit   m_commit_due;
  bit   m_page, m_disp, m_tgl, m_rel;
  int   m_drop;
  int   pend[$];
  logic [31:0] e_addr;
  logic [1:0]  e_data;
  bit   e_en, e_short, e_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", tag, s, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_commit_due = 0;
    m_page = 0; m_tgl = 0; m_rel = 1; m_drop = 0;
`ifdef GB_FB_DOUBLE_BUFFER_EN
    m_disp = 1;
`else
    m_disp = 0;
`endif
    pend.delete();
    e_en = 0; e_short = 0; e_ovf = 0;
  endtask

  task automatic model_step(input bit fs, input bit pv, input logic [1:0] ld);
    bit edge_now = 0;
    bit old_page = m_page;
    bit flip_now = m_commit_due;
    if (pend.size() > 0 && pend[0] == s) begin
      void'(pend.pop_front());
      edge_now = 1;
    end
    e_en = 0; e_short = 0; e_ovf = 0; m_commit_due = 0;
    if (flip_now) begin
`ifdef GB_FB_DOUBLE_BUFFER_EN
      if (m_rel) begin
        m_page = m_disp; m_disp = old_page; m_tgl = !m_tgl; m_rel = 0;
      end else if (m_drop < 255) begin
        m_drop++;
      end
`else
      m_tgl = !m_tgl;
`endif
    end
    if (edge_now) m_rel = 1;
    if (fs) begin
      if (m_phase == 1 && m_n > 0) e_short = 1;
      m_phase = 1;
      m_n = 0;
      if (pv) begin
        e_en = 1; e_addr = old_page * PAGE_OFS; e_data = ld; m_n = 1;
      end
    end else if (m_phase == 1) begin
      if (pv) begin
        e_en = 1; e_addr = old_page * PAGE_OFS + m_n; e_data = ld; m_n++;
        if (m_n == PIX) begin
          m_phase = 2; m_commit_due = 1;
        end
      end
    end else if (m_phase == 2 && pv) begin
      e_ovf = 1;
    end
  endtask

  task automatic step(input bit fs, input bit pv, input logic [1:0] ld);
    frame_start = fs; px_valid = pv; ld_in = ld;
    @(posedge clk); #1;
    model_step(fs, pv, ld);
    check("wr_en", 32'(wr_en), 32'(e_en));
    if (e_en) begin
      check("wr_addr", 32'(wr_addr), e_addr);
      check("wr_data", 32'(wr_data), 32'(e_data));
    end
    check("wr_page", 32'(wr_page), 32'(m_page));
    check("disp_page", 32'(disp_page), 32'(m_disp));
    check("frame_tgl", 32'(frame_tgl), 32'(m_tgl));
    check("short_frame", 32'(short_frame), 32'(e_short));
    check("overflow", 32'(overflow), 32'(e_ovf));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    s++;
    frame_start = 0; px_valid = 0;
  endtask

  task automatic toggle_rd();
`ifdef GB_FB_DOUBLE_BUFFER_EN
    rd_done_tgl = !rd_done_tgl;
    pend.push_back(s + SYNC_STAGES);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_wr_page"}, 32'(wr_page), 0);
`ifdef GB_FB_DOUBLE_BUFFER_EN
    check({tag, "_disp_page"}, 32'(disp_page), 1);
`else
    check({tag, "_disp_page"}, 32'(disp_page), 0);
`endif
    check({tag, "_frame_tgl"}, 32'(frame_tgl), 0);
    check({tag, "_short"}, 32'(short_frame), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1; frame_start = 0; px_valid = 0;
    #1;
    model_reset();
    check_reset_values(tag);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic full_frame(input bit ramp);
    step(1, 0, 2'd0);
    for (int i = 0; i < PIX; i++) step(0, 1, ramp ? 2'(i % 4) : 2'($urandom_range(0, 3)));
    step(0, 0, 2'd0);
    step(0, 0, 2'd0);
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
`ifdef GB_FB_DOUBLE_BUFFER_EN
      if (pend.size() == 0 && $urandom_range(0, 299) == 0) toggle_rd();
`endif
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    apply_reset("por");

    // Pixels before any frame start are ignored.
    for (int i = 0; i < 4; i++) step(0, 1, 2'($urandom_range(0, 3)));

    full_frame(1);
`ifdef GB_FB_DOUBLE_BUFFER_EN
    check("f1_wr_page", 32'(wr_page), 1);
    check("f1_disp_page", 32'(disp_page), 0);
`endif
    check("f1_frame_tgl", 32'(frame_tgl), 1);

    for (int i = 0; i < 5; i++) step(0, 1, 2'($urandom_range(0, 3)));

    full_frame(0);
`ifdef GB_FB_DOUBLE_BUFFER_EN
    check("f2_drop_cnt", 32'(drop_cnt), 1);
    check("f2_frame_tgl", 32'(frame_tgl), 1);
`else
    check("f2_drop_cnt", 32'(drop_cnt), 0);
    check("f2_frame_tgl", 32'(frame_tgl), 0);
`endif

    toggle_rd();
    for (int i = 0; i < 5; i++) step(0, 0, 2'd0);
    full_frame(0);
    check("f3_wr_page", 32'(wr_page), 0);

    // Frame start with a pixel, then a short frame after 100 pixels.
    step(1, 1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 99; i++) step(0, 1, 2'($urandom_range(0, 3)));
    step(1, 0, 2'd0);
    check("short_pulse", 32'(short_frame), 1);
    step(0, 1, 2'($urandom_range(0, 3)));
    check("after_short_addr", 32'(wr_addr), 32'(m_page) * PAGE_OFS);

    random_run(3000);

    // Reset in the middle of a frame.
    step(1, 0, 2'd0);
    for (int i = 0; i < 5000; i++) step(0, 1, 2'($urandom_range(0, 3)));
    apply_reset("mid");
    random_run(300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gb_frame_writer.md
# gb_frame_writer

Parametrised write-side controller for the Game Boy LCD framebuffer, clocked by the 2^22 Hz Game Boy clock. Turns the PPU pixel stream (`LD`/`PX_VALID`) into frame-aligned RAM write cycles with explicit x/y tracking, and resynchronises on every PPU frame start. Double-buffers with a page flip gated by a reader-release handshake from the VGA domain. Sits between the PPU pixel conduit and the dual-clock framebuffer RAM, in place of the bare free-running write counter.

## Interface
Parameters:
- `WIDTH`, 160, pixels per line.
- `HEIGHT`, 144, lines per frame.
- `PIX_W`, 2, bits per pixel.
- `SYNC_STAGES`, 2, synchroniser depth for `rd_done_tgl` (≥2).
- Derived `PA_W` = clog2(WIDTH*HEIGHT), 15 at defaults. `ADDR_W` = PA_W+1 with the config macro, PA_W without.

Ports (reset is GameBoy_reset, asynchronous, active-high; clock is GameBoy_clk):
- `GameBoy_clk`  in  1  Game Boy clock.
- `GameBoy_reset`  in  1  async active-high reset.
- `LD`  in  PIX_W  pixel value.
- `PX_VALID`  in  1  pixel strobe, one pixel per high cycle.
- `FRAME_START`  in  1  one-cycle pulse at PPU frame start (LY=0).
- `rd_done_tgl`  in  1  toggles (VGA domain) when the reader finishes scanning `disp_page`.
- `wr_en`  out  1  RAM write enable.
- `wr_addr`  out  ADDR_W  RAM address {page, pixel index}.
- `wr_data`  out  PIX_W  RAM data.
- `wr_page`  out  1  page currently being written.
- `disp_page`  out  1  page the reader must display.
- `frame_tgl`  out  1  toggles on every page flip or frame commit.
- `short_frame`  out  1  one-cycle pulse: `FRAME_START` arrived mid-frame.
- `overflow`  out  1  one-cycle pulse: pixel received after the frame completed.
- `drop_cnt`  out  8  saturating count of frames not flipped because the reader had not released.

## Operation
- States:
  - IDLE: after reset. `PX_VALID` ignored. `FRAME_START` → ACTIVE.
  - ACTIVE: each `PX_VALID` writes pixel (x,y) at index y*WIDTH+x. The index is kept as an incremental counter, with no multiplier. x wraps at WIDTH-1 and increments y. The pixel with x=WIDTH-1, y=HEIGHT-1 completes the frame → COMMIT.
  - COMMIT: single cycle. Performs the flip decision → DONE.
  - DONE: `PX_VALID` ignored and pulses `overflow`. `FRAME_START` → ACTIVE.
- Flip decision: if `released`=1, swap `wr_page`/`disp_page`, clear `released`, and toggle `frame_tgl`. Otherwise keep the pages (next frame overwrites `wr_page`) and increment `drop_cnt`, saturating at 255.
- `released` (reset 1): set on either edge of `rd_done_tgl` after the SYNC_STAGES-flop synchroniser plus an edge-detect flop. A set and a clear in the same cycle: the clear from COMMIT wins only if the edge was already registered. A same-cycle edge sets `released` after the flip.
- `FRAME_START` in ACTIVE with the frame not complete: pulse `short_frame`, zero x/y/index, stay ACTIVE, no flip.
- `FRAME_START` together with `PX_VALID` in any state: counters restart and that pixel is written at index 0. The pixel belongs to the new frame.
- Reset mid-frame: all state returns to reset values at once. Partial frame discarded and no flip.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `wr_page`=0, `disp_page`=1, `frame_tgl`=0, `short_frame`=0, `overflow`=0, `drop_cnt`=0, state IDLE, `released`=1.
- `wr_en`/`wr_addr`/`wr_data` are registered, one cycle after the accepted `PX_VALID`. `wr_en` is high for exactly one cycle per accepted pixel.
- Flip visible on `wr_page`/`disp_page`/`frame_tgl` two cycles after the final pixel's `PX_VALID` (the COMMIT cycle plus a register). The final pixel's write uses the old `wr_page`.
- `rd_done_tgl` to `released`: SYNC_STAGES+1 cycles.
- A `PX_VALID` during the COMMIT cycle is treated as in DONE: ignored, pulses `overflow`.

## Configuration
- `GB_FB_DOUBLE_BUFFER_EN` defined: two pages, behaviour as above, `ADDR_W`=PA_W+1.
- Undefined: single page. `wr_page`=`disp_page`=0 constant, `ADDR_W`=PA_W, no page bit. COMMIT always toggles `frame_tgl`. `rd_done_tgl` and the synchroniser are removed, and `drop_cnt` stays 0.

## Test plan
- Reset, `FRAME_START`, then 23040 `PX_VALID` with LD=i%4 → writes at {0,0}..{0,23039}, each one cycle late. `wr_page`=1, `disp_page`=0, `frame_tgl`=1 two cycles after the last pixel.
- Second full frame without toggling `rd_done_tgl` → no flip, `drop_cnt`=1. Toggle `rd_done_tgl`, then a third frame → flip, `wr_page`=0.
- `FRAME_START` after 100 pixels → `short_frame` pulse. Next pixel written at index 0, same page, `frame_tgl` unchanged.
- 5 extra `PX_VALID` after a completed frame → 5 `overflow` pulses, `wr_en` stays 0.
- `PX_VALID` in IDLE → no writes. `FRAME_START` and `PX_VALID` in the same cycle → write at index 0.
- Assert reset at pixel 5000 → all outputs at reset values. Macro undefined: `wr_addr` is 15 bits, `frame_tgl` toggles every frame, `drop_cnt`=0.
